// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the memory-cycle sequencer.
// Holds the FSM state encoding, 6502 rw polarity and parameter defaults.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    DATA = 2'd3
  } bus_state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int DEF_AW  = 16;
  localparam int DEF_DW  = 8;
  localparam int DEF_WSW = 3;
  localparam int DEF_TMO = 255;

  // Stall counter must be able to hold TMO; a disabled timeout still needs one bit.
  function automatic int stall_width(input int tmo);
    return (tmo > 0) ? $clog2(tmo + 1) : 1;
  endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Wait-state down-counter plus saturating rdy-stall up-counter.
// timeout fires on the stalled cycle that brings the stall count up to TMO.
module bus_wait_timer
  import mem_bus_pkg::*;
#(
  parameter int WSW = DEF_WSW,
  parameter int TMO = DEF_TMO
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           load,
  input  logic [WSW-1:0] load_val,
  input  logic           dec,
  input  logic           stall,
  output logic           wait_zero,
  output logic           timeout
);

  localparam int SCW = stall_width(TMO);

  logic [WSW-1:0] wait_cnt_reg;
  logic [SCW-1:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wait_cnt_reg  <= '0;
      stall_cnt_reg <= '0;
    end else if (load) begin
      wait_cnt_reg  <= load_val;
      stall_cnt_reg <= '0;
    end else begin
      if (dec && !wait_zero)
        wait_cnt_reg <= wait_cnt_reg - WSW'(1);
      if (stall && !(&stall_cnt_reg))
        stall_cnt_reg <= stall_cnt_reg + SCW'(1);
    end
  end

  assign wait_zero = (wait_cnt_reg == '0);
  assign timeout   = (TMO != 0) && stall && (int'(stall_cnt_reg) >= TMO - 1);

endmodule

// File: rtl/mem_bus_seq.sv
// Request/acknowledge memory-cycle sequencer driving address latch, rw, sync and doe.
// Supports programmable wait states, rdy stalls with timeout abort, and back-to-back transfers.
module mem_bus_seq
  import mem_bus_pkg::*;
#(
  parameter int AW  = DEF_AW,
  parameter int DW  = DEF_DW,
  parameter int WSW = DEF_WSW,
  parameter int TMO = DEF_TMO
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           req,
  output logic           ack,
  input  logic           we,
  input  logic           fetch,
  input  logic [AW-1:0]  addr,
  input  logic [DW-1:0]  wdata,
  input  logic [WSW-1:0] wait_cfg,
  input  logic           rdy,
  input  logic [DW-1:0]  din,
  output logic [AW-1:0]  ab,
  output logic [DW-1:0]  dout,
  output logic           doe,
  output logic           rw,
  output logic           sync,
  output logic [DW-1:0]  rdata,
  output logic           done,
  output logic           err,
  output logic           busy
);

  bus_state_t state_reg;
  logic       we_reg;
  logic       wait_zero;
  logic       timeout;
  logic       stall;
  logic       dec;

  assign ack   = req && ((state_reg == IDLE) || ((state_reg == DATA) && rdy));
  assign busy  = (state_reg != IDLE);
  assign dec   = (state_reg == ADDR) || (state_reg == WAIT);
  assign stall = ((state_reg == WAIT) && wait_zero && !rdy) ||
                 ((state_reg == DATA) && !rdy);

  bus_wait_timer #(
    .WSW (WSW),
    .TMO (TMO)
  ) u_timer (
    .clk       (clk),
    .clr       (clr),
    .load      (ack),
    .load_val  (wait_cfg),
    .dec       (dec),
    .stall     (stall),
    .wait_zero (wait_zero),
    .timeout   (timeout)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg <= IDLE;
      we_reg    <= 1'b0;
      ab        <= '0;
      dout      <= '0;
      doe       <= 1'b0;
      rw        <= RW_READ;
      sync      <= 1'b0;
      rdata     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_reg)
        IDLE: ;
        ADDR: begin
          sync      <= 1'b0;
          doe       <= we_reg;
          state_reg <= (!wait_zero || !rdy) ? WAIT : DATA;
        end
        WAIT: begin
          if (timeout) begin
            state_reg <= IDLE;
            err       <= 1'b1;
            rw        <= RW_READ;
            doe       <= 1'b0;
          end else if (wait_zero && rdy) begin
            state_reg <= DATA;
          end
        end
        DATA: begin
          if (rdy) begin
            done      <= 1'b1;
            if (!we_reg)
              rdata <= din;
            state_reg <= IDLE;
            rw        <= RW_READ;
            doe       <= 1'b0;
          end else if (timeout) begin
            state_reg <= IDLE;
            err       <= 1'b1;
            rw        <= RW_READ;
            doe       <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
      // An accept (from IDLE or a completing DATA) overrides the return to IDLE above.
      if (ack) begin
        state_reg <= ADDR;
        we_reg    <= we;
        ab        <= addr;
        rw        <= we ? RW_WRITE : RW_READ;
        sync      <= fetch;
        doe       <= 1'b0;
        if (we)
          dout <= wdata;
      end
    end
  end

endmodule

// File: doc/mem_bus_seq.md
Name: mem_bus_seq

Overview:
Parametrised memory-cycle sequencer. It replaces the hand-driven ablwa/abhwa/dorwa/rw strobing with a request/acknowledge engine.
- Accepts one bus request per transfer from the core control logic.
- Drives the address latch, rw, sync and the data-output enable.
- Inserts programmable wait states, honours a 6502-style rdy stall and aborts on timeout.
- Sits between the core control logic and the external address/data pins. The board-level tristate on dataio is built from dout/doe outside this block.

Parameters:
AW, 16, address width (abh:abl concatenated)
DW, 8, data width
WSW, 3, width of wait_cfg (0..2^WSW-1 wait states)
TMO, 255, max cycles stalled on rdy=0 before abort; 0 disables timeout

Ports:
clk  in  1  system clock, all state updates on rising edge
clr  in  1  asynchronous reset, active-low
req  in  1  core transfer request
ack  out  1  combinational; request accepted this cycle
we  in  1  1=write, 0=read; sampled on accept
fetch  in  1  opcode fetch (drives sync); sampled on accept
addr  in  AW  transfer address; sampled on accept
wdata  in  DW  write data; sampled on accept
wait_cfg  in  WSW  wait states for this transfer; sampled on accept
rdy  in  1  memory ready; 0 stalls the cycle
din  in  DW  data from pins (dataio input side)
ab  out  AW  registered address bus
dout  out  DW  registered write data
doe  out  1  data output enable to pin tristate
rw  out  1  1=read, 0=write (6502 polarity)
sync  out  1  high during ADDR of a fetch
rdata  out  DW  captured read data
done  out  1  one-cycle pulse, transfer completed
err  out  1  one-cycle pulse, transfer aborted by timeout
busy  out  1  state != IDLE

Behaviour:
- Reset values (clr=0, asynchronous): state IDLE; ab=0; dout=0; doe=0; rw=1; sync=0; rdata=0; done=0; err=0; counters 0.
- Reset mid-transfer abandons the transfer silently: no done, no err.
- States: IDLE, ADDR, WAIT, DATA.
- ack = req & (state==IDLE | (state==DATA & rdy)).
- On ack: latch addr/we/fetch/wdata/wait_cfg, load wait counter with wait_cfg, clear stall counter, go to ADDR.
- ADDR (exactly 1 cycle):
  - ab=latched addr; rw=~we; sync=fetch.
  - Next state: WAIT if wait_cfg!=0 or rdy=0; else DATA.
- WAIT:
  - Wait counter decrements each cycle while nonzero.
  - Goes to DATA when counter==0 and rdy=1.
  - The stall counter increments on every WAIT cycle with counter==0 and rdy=0.
  - When stall count reaches TMO (TMO!=0), go to IDLE with err pulsed the next cycle and rw=1, doe=0.
- DATA:
  - Completes when rdy=1. Reads sample din into rdata at the closing edge.
  - done pulses the cycle after DATA completes; rdata is valid from that cycle until the next read completes.
  - Next state is ADDR if ack (back-to-back), else IDLE.
  - rdy=0 in DATA holds DATA and increments the stall counter; the same timeout rule applies.
- Writes: rw=0 from ADDR through DATA; dout=wdata from ADDR; doe=1 only in WAIT and DATA.
- sync deasserts after ADDR. rw returns to 1 in IDLE.
- ab holds its last value in IDLE; it is not cleared.
- Latency, accept to done pulse: 3 + wait_cfg + stall cycles. Back-to-back throughput: one transfer per 2 + wait_cfg cycles.
- wait_cfg changes after accept have no effect on the current transfer.
- TMO counter saturates; it does not wrap.

Decomposition:
- Package mem_bus_pkg:
  - state enum (IDLE/ADDR/WAIT/DATA);
  - RW_READ=1, RW_WRITE=0 constants;
  - default AW/DW/WSW/TMO values.
- Sub-module bus_wait_timer: loadable wait down-counter plus saturating stall up-counter with a timeout compare. Outputs: wait_zero, timeout.
- The FSM and output registers stay in mem_bus_seq.

Test Plan:
1. Read, wait_cfg=0, rdy=1, addr=16'h0005, din=8'h3C:
   - ack in cycle 0; ab=0005 and rw=1 in cycle 1; DATA in cycle 2;
   - done pulses in cycle 3 with rdata=3C.
2. Write, wait_cfg=2, addr=16'h01FF, wdata=8'hA5:
   - rw=0 in cycles 1-4; doe=1 in cycles 2-4; dout=A5;
   - done in cycle 5; rw=1 afterward.
3. Back-to-back: fetch read of 16'h0006 followed by a read of 16'h0007, req held high, wait_cfg=0, rdy=1:
   - sync=1 only during the first ADDR;
   - ab=0006 then 0007 two cycles apart; two done pulses two cycles apart.
4. Stall and timeout with TMO=4:
   - rdy=0 for 3 cycles in WAIT, then 1 → completes with done, no err.
   - rdy held 0 → err pulses after 4 stall cycles; state returns to IDLE; rw=1, doe=0.
5. Reset mid-write:
   - clr=0 in WAIT → same cycle doe=0, rw=1, busy=0, ab=0; no done and no err afterward.
   - After release, a new read succeeds normally.
